// File: rtl/fb_line_prefetcher.sv
// fb_line_prefetcher: streams framebuffer scanlines into a ring of line buffers for a same-clock scanout reader
module fb_line_prefetcher #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int NUM_BUFFERS = 4,
    parameter int MAX_WORDS   = 256,
    parameter int LINE_WIDTH  = 10
) (
    input  logic                            sys_clk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           cfg_base,
    input  logic [ADDR_WIDTH-1:0]           cfg_stride,
    input  logic [$clog2(MAX_WORDS):0]      cfg_words,
    input  logic [LINE_WIDTH-1:0]           cfg_lines,
    input  logic                            frame_start,
    output logic [ADDR_WIDTH-1:0]           fb_address,
    output logic                            fb_access,
    input  logic                            fb_ack,
    input  logic [DATA_WIDTH-1:0]           fb_data,
    input  logic [$clog2(MAX_WORDS)-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_line_valid,
    input  logic                            line_done,
    output logic [$clog2(NUM_BUFFERS):0]    fill_level,
    output logic                            underrun,
    output logic                            busy
);
    localparam int WW = $clog2(MAX_WORDS) + 1;
    localparam int AW = WW - 1;
    localparam int FW = $clog2(NUM_BUFFERS) + 1;
    localparam int BW = $clog2(NUM_BUFFERS);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_SPACE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [ADDR_WIDTH-1:0]   line_addr;
    logic [WW-1:0]           words_q;
    logic [LINE_WIDTH-1:0]   lines_q;
    logic [LINE_WIDTH-1:0]   line_idx;
    logic [AW-1:0]           words_done;
    logic [BW-1:0]           wr_buf;
    logic [BW-1:0]           rd_buf;
    logic [FW-1:0]           fill;
    logic [DATA_WIDTH-1:0]   ram [NUM_BUFFERS*MAX_WORDS];

    logic                    ack_ok;
    logic                    line_end;
    logic                    release_ok;
    logic                    last_line;
    logic [FW-1:0]           fill_next;

    // an ack racing a restart is dropped so the flushed frame never sees it
    assign ack_ok        = fb_ack & (state == FETCH) & ~frame_start;
    assign line_end      = ack_ok & ({1'b0, words_done} == words_q - WW'(1));
    assign release_ok    = line_done & (fill != '0);
    assign fill_next     = fill + FW'(line_end) - FW'(release_ok);
    assign last_line     = (line_idx + LINE_WIDTH'(1)) == lines_q;
    assign fb_address    = line_addr + ADDR_WIDTH'(words_done);
    assign fb_access     = (state == FETCH) & ~fb_ack;
    assign rd_line_valid = fill != '0;
    assign fill_level    = fill;
    assign busy          = state != IDLE;

    // frame walk, ring pointers, occupancy and underrun tracking
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            stride_q   <= '0;
            line_addr  <= '0;
            words_q    <= '0;
            lines_q    <= '0;
            line_idx   <= '0;
            words_done <= '0;
            wr_buf     <= '0;
            rd_buf     <= '0;
            fill       <= '0;
            underrun   <= 1'b0;
        end else if (frame_start) begin
            stride_q   <= cfg_stride;
            words_q    <= cfg_words;
            lines_q    <= cfg_lines;
            line_addr  <= cfg_base;
            line_idx   <= '0;
            words_done <= '0;
            wr_buf     <= '0;
            rd_buf     <= '0;
            fill       <= '0;
            underrun   <= 1'b0;
            state      <= (cfg_words != '0 && cfg_lines != '0) ? FETCH : IDLE;
        end else begin
            fill     <= fill_next;
            underrun <= underrun | (line_done & ~release_ok);
            if (release_ok)
                rd_buf <= rd_buf + BW'(1);
            if (ack_ok)
                words_done <= line_end ? '0 : words_done + AW'(1);
            if (line_end) begin
                wr_buf    <= wr_buf + BW'(1);
                line_idx  <= line_idx + LINE_WIDTH'(1);
                line_addr <= line_addr + stride_q;
                state     <= last_line ? IDLE :
                             (fill_next == FW'(NUM_BUFFERS)) ? WAIT_SPACE : FETCH;
            end else if (state == WAIT_SPACE && fill < FW'(NUM_BUFFERS)) begin
                state <= FETCH;
            end
        end
    end

    // line buffer storage written by accepted fetch acks
    always_ff @(posedge sys_clk) begin
        if (ack_ok)
            ram[{wr_buf, words_done}] <= fb_data;
    end

    // registered read port on the head buffer
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= ram[{rd_buf, rd_addr}];
    end
endmodule
